// File: rtl/ysyx_22040125_config.sv
// rtl/ysyx_22040125_config.sv - shared constants for the ysyx_22040125 fetch unit
package ysyx_22040125_config;

    typedef enum logic [2:0] {
        IFU_IDLE = 3'd0,
        IFU_REQ  = 3'd1,
        IFU_WAIT = 3'd2,
        IFU_OUT  = 3'd3,
        IFU_HALT = 3'd4
    } ifu_state_e;

    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/ysyx_22040125_ifu_buf.sv
// rtl/ysyx_22040125_ifu_buf.sv - holding register for the fetched word presented to decode
module ysyx_22040125_ifu_buf
    import ysyx_22040125_config::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic        ready_i,
    input  logic [31:0] inst_i,
    input  logic [63:0] pc_i,
    input  logic        fault_i,
    output logic        valid_o,
    output logic [31:0] inst_o,
    output logic [63:0] pc_o,
    output logic        fault_o
);

    logic        valid_q;
    logic [31:0] inst_q;
    logic [63:0] pc_q;
    logic        fault_q;

    // Clear (redirect discard) beats load; the payload only changes on load so it
    // stays stable while decode stalls.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            inst_q  <= INST_NOP;
            pc_q    <= 64'd0;
            fault_q <= 1'b0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            inst_q  <= inst_i;
            pc_q    <= pc_i;
            fault_q <= fault_i;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign inst_o  = inst_q;
    assign pc_o    = pc_q;
    assign fault_o = fault_q;

endmodule

// File: rtl/ysyx_22040125_ifu.sv
// rtl/ysyx_22040125_ifu.sv - instruction fetch unit: PC, fetch FSM, redirect and halt
module ysyx_22040125_ifu
    import ysyx_22040125_config::*;
#(
    parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    output logic        inst_fault,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        halt
);

    ifu_state_e  state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic        halt_q, halt_d;
    logic        buf_load;
    logic        buf_clear;
    logic [63:0] redirect_tgt;

    assign redirect_tgt = {redirect_pc[63:2], 2'b00};

    // Request is a pure decode of registered state so memory never sees an input-to-output path.
    assign imem_req  = (state_q == IFU_REQ) && !halt_q;
    assign imem_addr = pc_q;

    // State, PC, kill and sticky halt registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IFU_IDLE;
            pc_q    <= RESET_PC;
            kill_q  <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
            halt_q  <= halt_d;
        end
    end

    // Next-state logic; a redirect overrides the PC in every state.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        kill_d    = kill_q;
        halt_d    = halt_q | halt;
        buf_load  = 1'b0;
        buf_clear = 1'b0;
        case (state_q)
            IFU_IDLE: state_d = IFU_REQ;
            IFU_REQ: begin
                if (halt_q) begin
                    state_d = IFU_HALT;
                end else if (imem_gnt) begin
                    state_d = IFU_WAIT;
                    kill_d  = redirect_valid;
                end
            end
            IFU_WAIT: begin
                if (imem_rvalid) begin
                    // A redirect landing with the response also drops it, so kill never leaks past WAIT.
                    if (kill_q || redirect_valid) begin
                        kill_d  = 1'b0;
                        state_d = IFU_REQ;
                    end else begin
                        buf_load = 1'b1;
                        pc_d     = pc_q + 64'd4;
                        state_d  = IFU_OUT;
                    end
                end else if (redirect_valid) begin
                    kill_d = 1'b1;
                end
            end
            IFU_OUT: begin
                if (redirect_valid) begin
                    buf_clear = 1'b1;
                    state_d   = IFU_REQ;
                end else if (inst_ready) begin
                    state_d = halt_q ? IFU_HALT : IFU_REQ;
                end
            end
            IFU_HALT: state_d = IFU_HALT;
            default:  state_d = IFU_IDLE;
        endcase
        if (redirect_valid) begin
            pc_d = redirect_tgt;
        end
    end

    ysyx_22040125_ifu_buf u_buf (
        .clk_i   (clk),
        .rst_i   (rst),
        .load_i  (buf_load),
        .clear_i (buf_clear),
        .ready_i (inst_ready),
        .inst_i  (imem_rdata),
        .pc_i    (pc_q),
        .fault_i (imem_err),
        .valid_o (inst_valid),
        .inst_o  (inst),
        .pc_o    (inst_pc),
        .fault_o (inst_fault)
    );

endmodule

// File: tb/tb_ysyx_22040125_ifu.sv
// tb/tb_ysyx_22040125_ifu.sv - self-checking bench for the ysyx_22040125 fetch unit
module tb_ysyx_22040125_ifu;
    import ysyx_22040125_config::*;

    localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst, imem_req, imem_gnt, imem_rvalid, imem_err;
    logic [63:0] imem_addr, inst_pc, redirect_pc;
    logic [31:0] imem_rdata, inst;
    logic        inst_valid, inst_ready, inst_fault, redirect_valid, halt;

    always #5 clk = ~clk;

    ysyx_22040125_ifu dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_err(imem_err),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .inst_pc(inst_pc), .inst_fault(inst_fault),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt)
    );

    typedef struct {
        int gnt_dly;
        int lat;
        int rdy_hold;
        int err;
        int exp_vcyc;
        int exp_nreq;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    bit          pend = 0;
    int          cnt = 0;
    logic [63:0] paddr = '0;
    int          lat_cfg = 1;
    int          gnt_pct = 100;
    int          gnt_wait = 0;
    int          err_sel = 0;
    logic [63:0] err_addr = '0;
    logic        s_req, s_gnt;
    logic [63:0] s_addr;

    bit          model_on = 0;
    logic [63:0] exp_pc;
    int          deliveries = 0;
    bit          hold_pend = 0;
    logic [63:0] hold_pc;
    logic [31:0] hold_inst;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == RPC) return 32'h0010_0093;
        return (a[31:0] * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic logic mem_err(input logic [63:0] a);
        case (err_sel)
            1:       return a == err_addr;
            2:       return a[4:2] == 3'b101;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out", name);
    endtask

    // Transaction-level reference: fetched words arrive in program order from the
    // expected PC, a redirect or reset restarts the stream, a stalled word stays put.
    task automatic model_step();
        if (imem_req) check("req_align", {62'd0, imem_addr[1:0]}, 64'd0);
        if (hold_pend) begin
            check("rnd_hold_valid", {63'd0, inst_valid}, 64'd1);
            check("rnd_hold_pc", inst_pc, hold_pc);
            check("rnd_hold_inst", {32'd0, inst}, {32'd0, hold_inst});
        end
        hold_pend = 0;
        if (rst) begin
            exp_pc = RPC;
        end else if (redirect_valid) begin
            exp_pc = {redirect_pc[63:2], 2'b00};
        end else if (inst_valid && inst_ready) begin
            check("rnd_pc", inst_pc, exp_pc);
            check("rnd_inst", {32'd0, inst}, {32'd0, mem_word(exp_pc)});
            check("rnd_fault", {63'd0, inst_fault}, {63'd0, mem_err(exp_pc)});
            exp_pc = exp_pc + 64'd4;
            deliveries++;
        end else if (inst_valid) begin
            hold_pend = 1;
            hold_pc   = inst_pc;
            hold_inst = inst;
        end
    endtask

    // One clock: sample at negedge, then advance the memory model after the edge.
    task automatic tick();
        @(negedge clk);
        s_req  = imem_req;
        s_gnt  = imem_gnt;
        s_addr = imem_addr;
        if (model_on) model_step();
        @(posedge clk);
        #1;
        cyc++;
        imem_rvalid = 1'b0;
        imem_err    = 1'b0;
        imem_rdata  = $urandom;
        if (s_req && s_gnt) begin
            pend  = 1;
            paddr = s_addr;
            cnt   = (lat_cfg == 0) ? int'($urandom_range(1, 3)) : lat_cfg;
        end
        if (pend) begin
            cnt--;
            if (cnt == 0) begin
                pend        = 0;
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(paddr);
                imem_err    = mem_err(paddr);
            end
        end
        imem_gnt = 1'b0;
        if (imem_req && !pend) begin
            if (gnt_wait > 0) gnt_wait--;
            else imem_gnt = ($urandom_range(0, 99) < gnt_pct);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        halt = 1'b0;
        tick();
        tick();
        pend = 0;
        imem_rvalid = 1'b0;
        imem_gnt = 1'b0;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic wait_valid(input string name, output int c);
        c = -1;
        for (int k = 0; k < 30; k++) begin
            if (inst_valid) begin
                c = cyc;
                break;
            end
            tick();
        end
        if (c < 0) timeout(name);
    endtask

    task automatic wait_req(input string name, output int c, output bit saw_v);
        c = -1;
        saw_v = 0;
        for (int k = 0; k < 30; k++) begin
            if (imem_req) begin
                c = cyc;
                break;
            end
            if (inst_valid) saw_v = 1;
            tick();
        end
        if (c < 0) timeout(name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vt[5];
        int   vc, rc, nreq;
        bit   sv, saw;

        rst = 1'b1; imem_gnt = 0; imem_rvalid = 0; imem_err = 0; imem_rdata = '0;
        inst_ready = 0; redirect_valid = 0; redirect_pc = '0; halt = 0;

        // {gnt delay, latency, ready hold, err, cycle of inst_valid, cycle of next req}
        vt[0] = '{0, 1, 0, 0, 3, 4};
        vt[1] = '{0, 1, 5, 0, 3, 9};
        vt[2] = '{2, 1, 0, 0, 5, 6};
        vt[3] = '{0, 3, 2, 1, 5, 8};
        vt[4] = '{1, 2, 1, 1, 5, 7};

        for (int i = 0; i < 5; i++) begin
            lat_cfg = vt[i].lat; gnt_pct = 100; err_sel = (vt[i].err != 0) ? 1 : 0;
            err_addr = RPC; inst_ready = 0;
            do_reset();
            gnt_wait = vt[i].gnt_dly;
            check("rst_valid", {63'd0, inst_valid}, 64'd0);
            check("rst_req", {63'd0, imem_req}, 64'd0);
            check("rst_addr", imem_addr, RPC);
            check("rst_inst", {32'd0, inst}, 64'h13);
            check("rst_pc", inst_pc, 64'd0);
            check("rst_fault", {63'd0, inst_fault}, 64'd0);
            wait_valid("v_valid", vc);
            check("v_vcyc", 64'(vc), 64'(vt[i].exp_vcyc));
            check("v_inst", {32'd0, inst}, 64'h0010_0093);
            check("v_pc", inst_pc, RPC);
            check("v_fault", {63'd0, inst_fault}, 64'(vt[i].err));
            saw = 0;
            for (int h = 0; h < vt[i].rdy_hold; h++) begin
                tick();
                if (imem_req) saw = 1;
            end
            check("v_stall_noreq", {63'd0, saw}, 64'd0);
            check("v_stall_valid", {63'd0, inst_valid}, 64'd1);
            check("v_stall_pc", inst_pc, RPC);
            inst_ready = 1;
            tick();
            inst_ready = 0;
            wait_req("v_nreq", rc, sv);
            check("v_nreq_cyc", 64'(rc), 64'(vt[i].exp_nreq));
            check("v_naddr", imem_addr, RPC + 64'd4);
        end

        // Redirect while waiting on memory: response dropped, fetch resumes at aligned target.
        lat_cfg = 3; gnt_pct = 100; err_sel = 0; inst_ready = 1;
        do_reset();
        tick();
        tick();
        redirect_valid = 1; redirect_pc = 64'h8000_0103;
        tick();
        redirect_valid = 0;
        wait_req("wait_redir_req", rc, sv);
        check("wait_redir_noinst", {63'd0, sv}, 64'd0);
        check("wait_redir_addr", imem_addr, 64'h8000_0100);
        wait_valid("wait_redir_valid", vc);
        check("wait_redir_pc", inst_pc, 64'h8000_0100);
        check("wait_redir_inst", {32'd0, inst}, {32'd0, mem_word(64'h8000_0100)});

        // Redirect and accept in the same OUT cycle: the word must not be delivered.
        lat_cfg = 1; inst_ready = 0;
        do_reset();
        wait_valid("out_redir_valid", vc);
        inst_ready = 1; redirect_valid = 1; redirect_pc = 64'h8000_0200;
        tick();
        redirect_valid = 0;
        check("out_redir_drop", {63'd0, inst_valid}, 64'd0);
        wait_req("out_redir_req", rc, sv);
        check("out_redir_addr", imem_addr, 64'h8000_0200);
        wait_valid("out_redir_valid2", vc);
        check("out_redir_pc", inst_pc, 64'h8000_0200);

        // Halt during WAIT: in-flight word still delivered, then fetch stops until reset.
        lat_cfg = 2; inst_ready = 1;
        do_reset();
        tick();
        tick();
        halt = 1;
        tick();
        halt = 0;
        wait_valid("halt_valid", vc);
        check("halt_pc", inst_pc, RPC);
        nreq = 0;
        for (int k = 0; k < 21; k++) begin
            tick();
            if (imem_req) nreq++;
        end
        check("halt_noreq", 64'(nreq), 64'd0);
        check("halt_novalid", {63'd0, inst_valid}, 64'd0);
        do_reset();
        wait_req("halt_restart", rc, sv);
        check("halt_restart_cyc", 64'(rc), 64'd1);
        check("halt_restart_addr", imem_addr, RPC);

        // Randomized traffic against the stream model, with one reset mid-flight.
        lat_cfg = 0; gnt_pct = 60; err_sel = 2; inst_ready = 0;
        do_reset();
        exp_pc = RPC; deliveries = 0; hold_pend = 0; model_on = 1;
        for (int i = 0; i < 2500; i++) begin
            inst_ready = ($urandom_range(0, 99) < 70);
            redirect_valid = ($urandom_range(0, 99) < 4);
            redirect_pc = {32'h0, 32'h8000_0000 | 32'($urandom_range(0, 1023))};
            rst = (i == 1200);
            tick();
        end
        model_on = 0;
        rst = 0; redirect_valid = 0;
        check("rnd_progress", {63'd0, deliveries >= 50}, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ysyx_22040125_ifu.md
# ysyx_22040125_ifu

Instruction fetch unit for the ysyx_22040125 RV64 core. Owns the PC, issues one 32-bit read at a time to instruction memory over a request/grant/response handshake, and presents each fetched word with its PC to the decoder over a valid/ready interface. It accepts branch/jump redirects from execute and a sticky halt request from ebreak. Sits between instruction memory and the decode stage.

## Interface
- RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset
- clk  in  1  core clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  read request valid
- imem_addr  out  64  read address, bits [1:0] always 0
- imem_gnt  in  1  memory accepts request this cycle
- imem_rvalid  in  1  read data valid, at least 1 cycle after gnt
- imem_rdata  in  32  instruction word
- imem_err  in  1  access fault, qualified by imem_rvalid
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode accepts instruction
- inst  out  32  instruction word
- inst_pc  out  64  PC of inst
- inst_fault  out  1  fetch raised imem_err
- redirect_valid  in  1  execute redirects fetch
- redirect_pc  in  64  redirect target; bits [1:0] ignored, forced 0
- halt  in  1  stop issuing fetches (sticky until rst)

## Operation
- States: IDLE, REQ, WAIT, OUT, HALT.
- IDLE: reset state; unconditionally -> REQ next cycle.
- REQ: imem_req=1, imem_addr=pc. On imem_gnt -> WAIT. If halt_q set -> HALT without requesting.
- WAIT: on imem_rvalid: if kill set, drop response, clear kill, -> REQ; else capture imem_rdata/imem_err/pc into output buffer, pc <= pc+4 (mod 2^64), -> OUT.
- OUT: inst_valid=1; buffer stable until handshake. inst_valid & inst_ready -> REQ (or HALT if halt_q).
- HALT: no requests; pending WAIT response still drained first (HALT entered only from REQ/OUT). Exit only via rst.
- Redirect (any state, highest priority): pc <= {redirect_pc[63:2],2'b00}. REQ with gnt same cycle -> WAIT with kill=1. REQ without gnt -> stay REQ; imem_addr shows new pc next cycle (memory samples address only on gnt). WAIT -> kill=1. OUT -> buffer discarded even if inst_ready same cycle, -> REQ. HALT/IDLE -> pc updated only.
- halt_q <= halt_q | halt; redirect and halt same cycle: both take effect.
- Single outstanding request; imem_rvalid outside WAIT ignored.

## Timing
- Reset values: state IDLE, pc RESET_PC, imem_req 0, imem_addr RESET_PC, inst_valid 0, inst 32'h0000_0013 (nop), inst_pc 0, inst_fault 0, kill 0, halt_q 0.
- Outputs registered except imem_req/imem_addr/inst_valid (decoded from state/pc registers; no combinational path from any input).
- Best case, 1-cycle memory, always-ready decode: rst low at cycle 0, IDLE; cycle 1 REQ+gnt; cycle 2 rvalid; cycle 3 inst_valid; cycle 4 next REQ. Throughput 1 inst / 3 cycles.
- Redirect in cycle n: first request to new target no earlier than n+1.
- rst mid-transaction: returns to IDLE; late imem_rvalid after reset ignored (arrives in IDLE/REQ).

## Structure
- Shared package ysyx_22040125_config: state encoding constants (IFU_IDLE..IFU_HALT), INST_NOP 32'h00000013, default RESET_PC.
- One sub-module: ysyx_22040125_ifu_buf, output holding register (inst, inst_pc, inst_fault, valid) with load/clear/handshake; FSM and PC stay in top.

## Test plan
- Reset release, memory returns 32'h00100093 one cycle after gnt -> imem_addr 0x80000000, inst_valid with inst 32'h00100093, inst_pc 0x80000000 on cycle 3; next imem_addr 0x80000004.
- inst_ready held low 5 cycles -> inst/inst_pc stable, no imem_req until accepted.
- redirect_pc 0x80000103 while in WAIT -> response dropped, inst_valid stays 0, next imem_addr 0x80000100.
- redirect and inst_ready same cycle in OUT -> instruction not delivered twice, inst_valid low next cycle, next fetch at redirect target.
- imem_err=1 with rvalid -> inst_fault=1 with that inst_pc; next fetch pc+4.
- halt pulsed during WAIT -> current instruction delivered, then imem_req stays 0 for 20 cycles; rst restarts at RESET_PC.
